// File: rtl/uart_apb_regif.sv
// APB4 completer for UART control/status registers, bridging accesses to the TX/RX FIFO handshakes.
// Optional feature macro UART_APB_STRB_EN: register writes honour pstrb_i byte lanes.
`ifndef DEFAULT_ADDR_WIDTH
`define DEFAULT_ADDR_WIDTH 32
`endif
`ifndef DEFAULT_DATA_WIDTH
`define DEFAULT_DATA_WIDTH 32
`endif

module uart_apb_regif #(
  parameter int unsigned ADDR_WIDTH  = `DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = `DEFAULT_DATA_WIDTH,
  parameter int unsigned FIFO_CNT_W  = 8,
  parameter int unsigned TX_TIMEOUT  = 16,
  parameter logic [31:0] CLK_DIV_RST = 32'h0000_28B0
) (
  input  logic                    clk_i,
  input  logic                    srst_i,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic [ADDR_WIDTH-1:0]   paddr_i,
  input  logic                    pwrite_i,
  input  logic [DATA_WIDTH-1:0]   pwdata_i,
  input  logic [DATA_WIDTH/8-1:0] pstrb_i,
  output logic                    pready_o,
  output logic [DATA_WIDTH-1:0]   prdata_o,
  output logic                    pslverr_o,
  output logic [1:0]              ctrl_o,
  output logic [1:0]              flush_o,
  output logic [2:0]              cfg_o,
  output logic [31:0]             clk_div_o,
  output logic [7:0]              tx_data_o,
  output logic                    tx_valid_o,
  input  logic                    tx_ready_i,
  input  logic [7:0]              rx_data_i,
  input  logic                    rx_valid_i,
  output logic                    rx_ready_o,
  input  logic [FIFO_CNT_W-1:0]   tx_count_i,
  input  logic [FIFO_CNT_W-1:0]   rx_count_i
);

  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned SW    = DATA_WIDTH / 8;
  localparam int unsigned TMO_W = $clog2(TX_TIMEOUT + 1);

  localparam logic [4:0] A_CTRL    = 5'h00;
  localparam logic [4:0] A_CFG     = 5'h04;
  localparam logic [4:0] A_CLK_DIV = 5'h08;
  localparam logic [4:0] A_TX_CNT  = 5'h0C;
  localparam logic [4:0] A_RX_CNT  = 5'h10;
  localparam logic [4:0] A_TX_DATA = 5'h14;
  localparam logic [4:0] A_RX_DATA = 5'h18;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DECODE  = 2'd1,
    S_WAIT_TX = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [4:0]       r_addr;
  logic             r_write;
  logic [DW-1:0]    r_wdata;
  logic [TMO_W-1:0] r_tmo;
  logic [1:0]       r_ctrl;
  logic [1:0]       r_flush;
  logic [2:0]       r_cfg;
  logic [31:0]      r_clk_div;
  logic [7:0]       r_tx_data;
  logic             r_tx_valid;
  logic             r_rx_ready;
  logic             r_pready;
  logic             r_pslverr;
  logic [DW-1:0]    r_prdata;

  logic             w_setup;
  logic             w_setup_tx;
  logic             w_setup_lane0;
  logic             w_resp;
  logic             w_err;
  logic             w_pop;
  logic             w_wr_ctrl;
  logic             w_wr_cfg;
  logic             w_wr_div;
  logic [DW-1:0]    w_rdata;
  logic [DW-1:0]    w_wmask;
  logic             w_unused;

`ifdef UART_APB_STRB_EN
  logic [SW-1:0]    r_strb;

  // Byte-lane write mask from the latched strobes
  always_comb begin
    w_wmask = '0;
    for (int i = 0; i < int'(SW); i++) begin
      w_wmask[i*8 +: 8] = {8{r_strb[i]}};
    end
  end

  assign w_setup_lane0 = pstrb_i[0];
  assign w_unused      = ^paddr_i[ADDR_WIDTH-1:5];
`else
  assign w_wmask       = '1;
  assign w_setup_lane0 = 1'b1;
  assign w_unused      = ^{paddr_i[ADDR_WIDTH-1:5], pstrb_i};
`endif

  assign w_setup    = psel_i & ~penable_i;
  assign w_setup_tx = w_setup & pwrite_i & (paddr_i[4:0] == A_TX_DATA) & w_setup_lane0;

  // Next-state, decode and response generation
  always_comb begin
    w_state_nxt = r_state;
    w_resp      = 1'b0;
    w_err       = 1'b0;
    w_rdata     = '0;
    w_pop       = 1'b0;
    w_wr_ctrl   = 1'b0;
    w_wr_cfg    = 1'b0;
    w_wr_div    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_setup) w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (!psel_i) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
          w_resp      = 1'b1;
          case (r_addr)
            A_CTRL:    if (r_write) w_wr_ctrl = 1'b1; else w_rdata = DW'(r_ctrl);
            A_CFG:     if (r_write) w_wr_cfg  = 1'b1; else w_rdata = DW'(r_cfg);
            A_CLK_DIV: if (r_write) w_wr_div  = 1'b1; else w_rdata = DW'(r_clk_div);
            A_TX_CNT:  if (r_write) w_err = 1'b1; else w_rdata = DW'(tx_count_i);
            A_RX_CNT:  if (r_write) w_err = 1'b1; else w_rdata = DW'(rx_count_i);
            A_TX_DATA: begin
              // r_tx_valid is clear here only when the byte-0 strobe was missing
              if (!r_write || !r_tx_valid) begin
                w_err = 1'b1;
              end else if (!tx_ready_i) begin
                w_state_nxt = S_WAIT_TX;
                w_resp      = 1'b0;
              end
            end
            A_RX_DATA: begin
              if (r_write || !rx_valid_i) begin
                w_err = 1'b1;
              end else begin
                w_pop   = 1'b1;
                w_rdata = DW'(rx_data_i);
              end
            end
            default: w_err = 1'b1;
          endcase
        end
      end
      S_WAIT_TX: begin
        if (!psel_i) begin
          w_state_nxt = S_IDLE;
        end else if (tx_ready_i) begin
          w_state_nxt = S_RESP;
          w_resp      = 1'b1;
        end else if (r_tmo == TMO_W'(TX_TIMEOUT - 1)) begin
          w_state_nxt = S_RESP;
          w_resp      = 1'b1;
          w_err       = 1'b1;
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (w_err) w_rdata = '0;
  end

  // State, transfer latch, registers and registered outputs
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_tmo      <= '0;
      r_ctrl     <= '0;
      r_flush    <= '0;
      r_cfg      <= '0;
      r_clk_div  <= CLK_DIV_RST;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_rx_ready <= 1'b0;
      r_pready   <= 1'b0;
      r_pslverr  <= 1'b0;
      r_prdata   <= '0;
`ifdef UART_APB_STRB_EN
      r_strb     <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_pready   <= w_resp;
      r_pslverr  <= w_err;
      r_prdata   <= w_rdata;
      r_rx_ready <= w_pop;
      r_flush    <= '0;
      r_tmo      <= (r_state == S_WAIT_TX) ? r_tmo + TMO_W'(1) : '0;

      if (r_state == S_IDLE && w_setup) begin
        r_addr     <= paddr_i[4:0];
        r_write    <= pwrite_i;
        r_wdata    <= pwdata_i;
        r_tx_valid <= w_setup_tx;
`ifdef UART_APB_STRB_EN
        r_strb     <= pstrb_i;
`endif
        if (w_setup_tx) r_tx_data <= pwdata_i[7:0];
      end else if (w_state_nxt != S_WAIT_TX) begin
        r_tx_valid <= 1'b0;
      end

      if (w_wr_ctrl) begin
        r_ctrl  <= (r_ctrl & ~w_wmask[1:0]) | (r_wdata[1:0] & w_wmask[1:0]);
        r_flush <= r_wdata[3:2] & w_wmask[3:2];
      end
      if (w_wr_cfg) r_cfg     <= (r_cfg & ~w_wmask[2:0]) | (r_wdata[2:0] & w_wmask[2:0]);
      if (w_wr_div) r_clk_div <= (r_clk_div & ~w_wmask[31:0]) | (r_wdata[31:0] & w_wmask[31:0]);
    end
  end

  assign pready_o   = r_pready;
  assign prdata_o   = r_prdata;
  assign pslverr_o  = r_pslverr;
  assign ctrl_o     = r_ctrl;
  assign flush_o    = r_flush;
  assign cfg_o      = r_cfg;
  assign clk_div_o  = r_clk_div;
  assign tx_data_o  = r_tx_data;
  assign tx_valid_o = r_tx_valid;
  assign rx_ready_o = r_rx_ready;

endmodule

// File: tb/tb_uart_apb_regif.sv
// Scoreboard bench for uart_apb_regif: randomized APB traffic against a register/FIFO reference model.
`timescale 1ns/1ps
module tb_uart_apb_regif;

`ifdef UART_APB_STRB_EN
  localparam bit STRB_EN = 1'b1;
`else
  localparam bit STRB_EN = 1'b0;
`endif
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        srst_i = 1'b1;
  logic        psel_i = 1'b0;
  logic        penable_i = 1'b0;
  logic [31:0] paddr_i = '0;
  logic        pwrite_i = 1'b0;
  logic [31:0] pwdata_i = '0;
  logic [3:0]  pstrb_i = '0;
  logic        pready_o;
  logic [31:0] prdata_o;
  logic        pslverr_o;
  logic [1:0]  ctrl_o;
  logic [1:0]  flush_o;
  logic [2:0]  cfg_o;
  logic [31:0] clk_div_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b0;
  logic [7:0]  rx_data_i = '0;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic [7:0]  tx_count_i = '0;
  logic [7:0]  rx_count_i = '0;

  uart_apb_regif dut (
    .clk_i(clk), .srst_i(srst_i), .psel_i(psel_i), .penable_i(penable_i),
    .paddr_i(paddr_i), .pwrite_i(pwrite_i), .pwdata_i(pwdata_i), .pstrb_i(pstrb_i),
    .pready_o(pready_o), .prdata_o(prdata_o), .pslverr_o(pslverr_o),
    .ctrl_o(ctrl_o), .flush_o(flush_o), .cfg_o(cfg_o), .clk_div_o(clk_div_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_count_i(tx_count_i), .rx_count_i(rx_count_i)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] rdata; logic err; } resp_t;

  int n_tests = 0;
  int n_fail  = 0;
  resp_t exp_q[$];

  // Reference model state
  logic [31:0] m_ctrl = 32'h0, m_cfg = 32'h0, m_div = 32'h0000_28B0;
  logic [7:0]  m_rx[$];

  // Environment state: RX FIFO contents, TX ready delay, observed events
  logic [7:0]  rx_fifo[$];
  int          tx_delay = 0;
  int          vcnt = 0;
  int          tx_push_cnt = 0, rx_pop_cnt = 0, flush_cnt = 0;
  logic [7:0]  last_push = '0;
  logic [1:0]  last_flush = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic logic lane_on(input logic [3:0] s, input int i);
    return !STRB_EN || s[i];
  endfunction

  function automatic logic [31:0] apply_wr(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [3:0] s, input logic [31:0] writable);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (lane_on(s, i)) r[8*i +: 8] = wd[8*i +: 8];
    return r & writable;
  endfunction

  // Predicts response, side effects and access-phase length of one transfer
  task automatic model(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       input logic [3:0] s, input int delay, input logic [7:0] tcnt,
                       input logic [7:0] rcnt, output resp_t e, output logic push,
                       output logic pop, output logic [1:0] fl, output int lat);
    e = '0; push = 1'b0; pop = 1'b0; fl = 2'b00; lat = 2;
    case (addr[4:0])
      5'h00: if (wr) begin
               m_ctrl = apply_wr(m_ctrl, wd, s, 32'h3);
               fl = lane_on(s, 0) ? wd[3:2] : 2'b00;
             end else e.rdata = m_ctrl;
      5'h04: if (wr) m_cfg = apply_wr(m_cfg, wd, s, 32'h7); else e.rdata = m_cfg;
      5'h08: if (wr) m_div = apply_wr(m_div, wd, s, 32'hFFFF_FFFF); else e.rdata = m_div;
      5'h0C: if (wr) e.err = 1'b1; else e.rdata = {24'h0, tcnt};
      5'h10: if (wr) e.err = 1'b1; else e.rdata = {24'h0, rcnt};
      5'h14: begin
        if (!wr || !lane_on(s, 0)) e.err = 1'b1;
        else if (delay > TMO) begin e.err = 1'b1; lat = 2 + TMO; end
        else begin push = 1'b1; lat = 2 + delay; end
      end
      5'h18: begin
        if (wr || m_rx.size() == 0) e.err = 1'b1;
        else begin e.rdata = {24'h0, m_rx.pop_front()}; pop = 1'b1; end
      end
      default: e.err = 1'b1;
    endcase
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_ctrl"},    {30'h0, ctrl_o}, m_ctrl);
    check({tag, "_cfg"},     {29'h0, cfg_o},  m_cfg);
    check({tag, "_clk_div"}, clk_div_o,       m_div);
  endtask

  task automatic rx_load(input logic [7:0] b);
    rx_fifo.push_back(b);
    m_rx.push_back(b);
  endtask

  task automatic apb_setup(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                           input logic [3:0] s);
    psel_i = 1'b1; penable_i = 1'b0;
    paddr_i = addr; pwrite_i = wr; pwdata_i = wd; pstrb_i = s;
    @(posedge clk); #1;
  endtask

  task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                          input logic [3:0] s, input int delay);
    resp_t e; logic push, pop; logic [1:0] fl; int lat, exp_lat, push0, pop0, fl0;
    tx_delay = delay;
    tx_count_i = 8'($urandom); rx_count_i = 8'($urandom);
    model(addr, wr, wd, s, delay, tx_count_i, rx_count_i, e, push, pop, fl, exp_lat);
    exp_q.push_back(e);
    push0 = tx_push_cnt; pop0 = rx_pop_cnt; fl0 = flush_cnt;
    apb_setup(addr, wr, wd, s);
    penable_i = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!pready_o && lat < 64);
    check("latency", 32'(lat), 32'(exp_lat));
    @(posedge clk); #1;
    psel_i = 1'b0; penable_i = 1'b0;
    @(negedge clk); #1;
    check("tx_pushes", 32'(tx_push_cnt - push0), {31'h0, push});
    if (push) check("tx_data", {24'h0, last_push}, {24'h0, wd[7:0]});
    check("rx_pops", 32'(rx_pop_cnt - pop0), {31'h0, pop});
    check("flush_pulses", 32'(flush_cnt - fl0), {31'h0, fl != 2'b00});
    if (fl != 2'b00) check("flush_val", {30'h0, last_flush}, {30'h0, fl});
    check("tx_valid_idle", {31'h0, tx_valid_o}, 32'h0);
    check_regs("post");
  endtask

  // Transfer abandoned by dropping psel after n_acc access cycles
  task automatic apb_abort(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                           input int n_acc);
    int push0, pop0;
    tx_delay = 1000;
    push0 = tx_push_cnt; pop0 = rx_pop_cnt;
    apb_setup(addr, wr, wd, 4'hF);
    if (n_acc > 0) begin
      penable_i = 1'b1;
      repeat (n_acc) @(posedge clk);
      #1;
    end
    psel_i = 1'b0; penable_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("abort_tx_valid", {31'h0, tx_valid_o}, 32'h0);
    check("abort_pushes", 32'(tx_push_cnt - push0), 32'h0);
    check("abort_pops", 32'(rx_pop_cnt - pop0), 32'h0);
    check_regs("abort");
  endtask

  // Scoreboard monitor: every completed transfer is compared with the oldest prediction
  always @(negedge clk) begin : monitor
    resp_t e;
    if (pready_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_pready: prdata 0x%08h pslverr %0b with nothing outstanding",
                 prdata_o, pslverr_o);
      end else begin
        e = exp_q.pop_front();
        check("prdata", prdata_o, e.rdata);
        check("pslverr", {31'h0, pslverr_o}, {31'h0, e.err});
      end
    end
  end

  // FIFO-side environment: TX ready after tx_delay valid cycles, RX FIFO pops on rx_ready_o
  always begin : env
    logic pop_now;
    @(negedge clk);
    pop_now = (rx_ready_o === 1'b1);
    if (tx_valid_o === 1'b1 && tx_ready_i) begin tx_push_cnt++; last_push = tx_data_o; end
    if (flush_o !== 2'b00 && !$isunknown(flush_o)) begin flush_cnt++; last_flush = flush_o; end
    @(posedge clk); #1;
    if (pop_now) begin
      if (rx_fifo.size() > 0) void'(rx_fifo.pop_front());
      rx_pop_cnt++;
    end
    if (tx_valid_o === 1'b1) vcnt++; else vcnt = 0;
    tx_ready_i = (tx_valid_o === 1'b1) && (vcnt > tx_delay);
    rx_valid_i = rx_fifo.size() > 0;
    rx_data_i  = rx_valid_i ? rx_fifo[0] : 8'h00;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    logic [4:0] map_a [7];
    map_a = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18};

    repeat (3) @(posedge clk);
    #1;
    check("rst_pready",   {31'h0, pready_o},   32'h0);
    check("rst_prdata",   prdata_o,            32'h0);
    check("rst_pslverr",  {31'h0, pslverr_o},  32'h0);
    check("rst_flush",    {30'h0, flush_o},    32'h0);
    check("rst_tx_valid", {31'h0, tx_valid_o}, 32'h0);
    check("rst_tx_data",  {24'h0, tx_data_o},  32'h0);
    check("rst_rx_ready", {31'h0, rx_ready_o}, 32'h0);
    check_regs("rst");
    srst_i = 1'b0;
    @(negedge clk); #1;

    apb_xfer(32'h08, 1'b0, 32'h0, 4'hF, 0);
    apb_xfer(32'h00, 1'b1, 32'hF, 4'hF, 0);
    apb_xfer(32'h00, 1'b0, 32'h0, 4'hF, 0);
    apb_xfer(32'h14, 1'b1, 32'hA5, 4'hF, 5);
    apb_xfer(32'h14, 1'b1, 32'h5A, 4'hF, 1000);
    apb_xfer(32'h14, 1'b1, 32'h11, 4'hF, TMO);
    apb_xfer(32'h14, 1'b1, 32'h22, 4'hF, TMO + 1);
    apb_xfer(32'h18, 1'b0, 32'h0, 4'hF, 0);
    rx_load(8'h3C);
    apb_xfer(32'h18, 1'b0, 32'h0, 4'hF, 0);
    apb_xfer(32'h14, 1'b0, 32'h0, 4'hF, 0);
    apb_xfer(32'h0C, 1'b1, 32'h1, 4'hF, 0);
    apb_xfer(32'h1C, 1'b0, 32'h0, 4'hF, 0);
    apb_xfer(32'h08, 1'b1, 32'h0, 4'hF, 0);
    apb_xfer(32'h08, 1'b1, 32'hFFFF_FFFF, 4'b0010, 0);
    apb_xfer(32'h08, 1'b0, 32'h0, 4'hF, 0);
    apb_xfer(32'h14, 1'b1, 32'h77, 4'b1110, 0);

    apb_abort(32'h00, 1'b1, 32'h0, 0);
    rx_load(8'hC3);
    apb_abort(32'h18, 1'b0, 32'h0, 0);
    apb_abort(32'h14, 1'b1, 32'h99, 4);
    apb_xfer(32'h18, 1'b0, 32'h0, 4'hF, 0);

    // Reset in the middle of a stalled TX write
    tx_delay = 1000;
    apb_setup(32'h14, 1'b1, 32'h66, 4'hF);
    penable_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    srst_i = 1'b1;
    @(posedge clk); #1;
    srst_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0;
    m_ctrl = 32'h0; m_cfg = 32'h0; m_div = 32'h0000_28B0;
    @(negedge clk); #1;
    check("midrst_tx_valid", {31'h0, tx_valid_o}, 32'h0);
    check_regs("midrst");

    for (int n = 0; n < 250; n++) begin
      logic [31:0] addr, wd;
      logic [3:0]  s;
      logic        wr;
      int          d, r;
      if ($urandom_range(0, 3) == 0) rx_load(8'($urandom));
      addr = $urandom;
      addr[4:0] = ($urandom_range(0, 3) != 0) ? map_a[$urandom_range(0, 6)] : 5'($urandom);
      wr = 1'($urandom);
      wd = $urandom;
      s  = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      r  = $urandom_range(0, 9);
      if (r < 6)       d = $urandom_range(0, 3);
      else if (r < 8)  d = TMO + (r - 6);
      else if (r == 8) d = $urandom_range(0, 20);
      else             d = 100;
      apb_xfer(addr, wr, wd, s, d);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drain", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
